// File: rtl/ttl74138_seq_decoder.sv
// rtl/ttl74138_seq_decoder.sv - registered 74138-style 3-to-8 decoder with manual and auto-scan modes
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   g1     - enable, active-high
//   g2a_n  - enable, active-low
//   g2b_n  - enable, active-low
//   code   - manual code {C,B,A}
//   mode   - 0 = manual decode, 1 = auto-scan
//   hold   - 1 = freeze the scan
//   y_n    - registered active-low decoded lines
//   idx    - registered index of the selected line
//   valid  - 1 when exactly one y_n line is low
//   tick   - one-cycle pulse coincident with each scan step
module ttl74138_seq_decoder #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       g1,
    input  logic       g2a_n,
    input  logic       g2b_n,
    input  logic [2:0] code,
    input  logic       mode,
    input  logic       hold,
    output logic [7:0] y_n,
    output logic [2:0] idx,
    output logic       valid,
    output logic       tick
);

    localparam int PW = $clog2((TICK_DIV > 2) ? TICK_DIV : 2);
    localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2,
        PAUSE  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [2:0]    idx_next;
    logic [7:0]    y_n_next;
    logic          valid_next;
    logic          tick_next;
    logic          en;

    assign en = g1 & ~g2a_n & ~g2b_n;

    function automatic logic [7:0] decode(input logic [2:0] c);
        return ~(8'b1 << c);
    endfunction

    always_comb begin
        state_next = state;
        presc_next = presc;
        idx_next   = idx;
        y_n_next   = decode(idx);
        valid_next = 1'b1;
        tick_next  = 1'b0;

        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = mode ? SCAN : MANUAL;
                MANUAL:  if (mode) state_next = SCAN;
                SCAN: begin
                    if (!mode)     state_next = MANUAL;
                    else if (hold) state_next = PAUSE;
                end
                PAUSE: begin
                    if (!mode)      state_next = MANUAL;
                    else if (!hold) state_next = SCAN;
                end
                default: state_next = IDLE;
            endcase
        end

        // Outputs are a function of the state being entered, so every
        // register lands on the same edge as the state change.
        case (state_next)
            IDLE: begin
                presc_next = '0;
                y_n_next   = 8'hFF;
                valid_next = 1'b0;
            end
            MANUAL: begin
                presc_next = '0;
                idx_next   = code;
                y_n_next   = decode(code);
            end
            SCAN: begin
                // Only a cycle spent wholly in SCAN advances the prescaler;
                // resuming from PAUSE keeps the held count.
                if (state == SCAN) begin
                    if (presc == TERM) begin
                        presc_next = '0;
                        idx_next   = idx + 3'd1;
                        tick_next  = 1'b1;
                    end else begin
                        presc_next = presc + 1'b1;
                    end
                end
                y_n_next = decode(idx_next);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            presc <= '0;
            y_n   <= 8'hFF;
            idx   <= 3'd0;
            valid <= 1'b0;
            tick  <= 1'b0;
        end else begin
            state <= state_next;
            presc <= presc_next;
            y_n   <= y_n_next;
            idx   <= idx_next;
            valid <= valid_next;
            tick  <= tick_next;
        end
    end

endmodule

// File: tb/tb_ttl74138_seq_decoder.sv
// tb/tb_ttl74138_seq_decoder.sv - self-checking bench for ttl74138_seq_decoder
module tb_ttl74138_seq_decoder;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, g1, g2a_n, g2b_n, mode, hold;
    logic [2:0] code;
    logic [7:0] y_n;
    logic [2:0] idx;
    logic       valid, tick;

    always #5 clk = ~clk;

    ttl74138_seq_decoder #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .g1(g1), .g2a_n(g2a_n), .g2b_n(g2b_n),
        .code(code), .mode(mode), .hold(hold),
        .y_n(y_n), .idx(idx), .valid(valid), .tick(tick)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: tracks whether the decoder is on, scanning or paused, and
    // counts edges spent scanning; a step happens on every TD-th such edge.
    bit         m_on, m_scan, m_paused;
    int         m_phase, m_idx;
    logic [7:0] m_yn;
    bit         m_valid, m_tick;

    task automatic model_step();
        bit en;
        en = g1 && !g2a_n && !g2b_n;
        m_tick = 0;
        if (rst) begin
            m_on = 0; m_scan = 0; m_paused = 0; m_phase = 0; m_idx = 0;
        end else if (!en) begin
            m_on = 0; m_scan = 0; m_paused = 0; m_phase = 0;
        end else if (!mode) begin
            m_on = 1; m_scan = 0; m_paused = 0; m_phase = 0; m_idx = int'(code);
        end else if (!m_scan) begin
            m_on = 1; m_scan = 1; m_paused = 0; m_phase = 0;
        end else if (hold) begin
            m_paused = 1;
        end else if (m_paused) begin
            m_paused = 0;
        end else begin
            m_phase++;
            if (m_phase == TD) begin
                m_phase = 0;
                m_idx = (m_idx + 1) % 8;
                m_tick = 1;
            end
        end
        m_valid = m_on;
        m_yn = m_on ? 8'(255 - (1 << m_idx)) : 8'hFF;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check("y_n", y_n, m_yn);
        check("idx", idx, m_idx);
        check("valid", valid, m_valid);
        check("tick", tick, m_tick);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int tick_cnt;
    logic [2:0] tick_idx [$];
    logic [2:0] frozen;

    initial begin
        m_on = 0; m_scan = 0; m_paused = 0; m_phase = 0; m_idx = 0;
        m_yn = 8'hFF; m_valid = 0; m_tick = 0;

        // 1. reset with arbitrary inputs, then manual decode of 5
        rst = 1; g1 = $urandom; g2a_n = $urandom; g2b_n = $urandom;
        code = 3'($urandom); mode = $urandom; hold = $urandom;
        steps(2);
        check("rst_yn", y_n, 8'hFF);
        check("rst_idx", idx, 0);
        check("rst_valid", valid, 0);
        check("rst_tick", tick, 0);
        rst = 0; g1 = 1; g2a_n = 0; g2b_n = 0; mode = 0; hold = 0; code = 3'd5;
        step();
        check("t1_yn", y_n, 8'b1101_1111);
        check("t1_idx", idx, 5);

        // 2. each enable gates the decode
        code = 3'd2; step();
        g2b_n = 1; step(); check("t2_g2b_off", y_n, 8'hFF); check("t2_g2b_valid", valid, 0);
        g2b_n = 0; step(); check("t2_g2b_on", y_n, 8'b1111_1011);
        g1 = 0;    step(); check("t2_g1_off", y_n, 8'hFF);
        g1 = 1;    step(); check("t2_g1_on", y_n, 8'b1111_1011);
        g2a_n = 1; step(); check("t2_g2a_off", y_n, 8'hFF);
        g2a_n = 0; step(); check("t2_g2a_on", y_n, 8'b1111_1011);

        // 3. scan walk from 6 with wrap
        code = 3'd6; step();
        mode = 1; step();
        tick_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (tick) begin
                tick_cnt++;
                tick_idx.push_back(idx);
                if (idx == 3'd0) check("t3_yn_idx0", y_n, 8'b1111_1110);
            end
        end
        check("t3_ticks", tick_cnt, 4);
        check("t3_seq0", tick_idx[0], 7);
        check("t3_seq1", tick_idx[1], 0);
        check("t3_seq2", tick_idx[2], 1);

        // 4. pause with prescaler at 2
        steps(2);
        frozen = idx;
        hold = 1; steps(10);
        check("t4_frozen", idx, frozen);
        hold = 0; step(); check("t4_resume_tick", tick, 0);
        step(); check("t4_tick_early", tick, 0);
        step(); check("t4_tick", tick, 1);

        // 5. mode change and hold at terminal count
        steps(3);
        mode = 0; code = 3'd4; step();
        check("t5_mode_tick", tick, 0); check("t5_mode_idx", idx, 4);
        mode = 1; step(); steps(3);
        frozen = idx;
        hold = 1; step();
        check("t5_hold_tick", tick, 0); check("t5_hold_idx", idx, frozen);
        hold = 0;

        // 6. reset mid-scan at idx 3
        mode = 0; code = 3'd2; step();
        mode = 1; step(); steps(4); steps(2);
        check("t6_pre_idx", idx, 3);
        rst = 1; step();
        check("t6_rst_yn", y_n, 8'hFF); check("t6_rst_idx", idx, 0);
        rst = 0; step();
        steps(3); check("t6_no_tick", tick, 0);
        step(); check("t6_tick", tick, 1); check("t6_idx", idx, 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(99) == 0);
            g1    = ($urandom_range(15) != 0);
            g2a_n = ($urandom_range(19) == 0);
            g2b_n = ($urandom_range(19) == 0);
            if ($urandom_range(19) == 0) mode = ~mode;
            if ($urandom_range(9) == 0) hold = ~hold;
            code = 3'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
